// File: rtl/cu_decimation_mc.sv
// Multi-channel ADC decimator: pick-last or boxcar over 2^rate strobes, TDM output.
// Define CU_DEC_ROUND_EN for round-half-up averaging (default: floor).
module cu_decimation_mc #(
   parameter int WIDTH    = 16,
   parameter int CH       = 4,
   parameter int CHW      = 2,
   parameter int RATE_MAX = 7,
   parameter int RW       = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                drdy,
   input  logic [CH*WIDTH-1:0] datain,
   input  logic [RW-1:0]       rate,
   input  logic                mode,
   output logic [WIDTH-1:0]    dataout,
   output logic [CHW-1:0]      chan_out,
   output logic                data_rdy,
   output logic                frame_start,
   output logic                busy,
   output logic                overrun
);
   localparam int AW = WIDTH + RATE_MAX;
   localparam int NW = RATE_MAX + 1;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic                 r_s1, r_s2, r_s3;
   logic [NW-1:0]        r_cnt;
   logic [RW-1:0]        r_rate;
   logic                 r_mode;
   logic signed [AW-1:0] r_acc  [CH];
   logic [WIDTH-1:0]     r_res  [CH];
   logic [WIDTH-1:0]     r_snap [CH];
   logic                 r_done;
   logic                 r_go;
   state_t               r_st;

   logic                 w_stb;
   logic                 w_first;
   logic                 w_last;
   logic                 w_mode;
   logic [RW-1:0]        w_rate_new;
   logic [RW-1:0]        w_rate;
   logic [NW-1:0]        w_n;
   logic [CHW-1:0]       w_nxt;
   logic signed [AW-1:0] w_rnd;
   logic signed [AW-1:0] w_sum [CH];
   logic [WIDTH-1:0]     w_res [CH];

   assign w_stb      = r_s2 & ~r_s3;
   assign w_first    = (r_cnt == '0);
   assign w_rate_new = (int'(rate) > RATE_MAX) ? RW'(RATE_MAX) : rate;
   assign w_rate     = w_first ? w_rate_new : r_rate;
   assign w_mode     = w_first ? mode : r_mode;
   assign w_n        = NW'(1) << w_rate;
   assign w_last     = (r_cnt == w_n - 1'b1);
   assign w_nxt      = chan_out + 1'b1;

   always_comb begin
      w_rnd = '0;
`ifdef CU_DEC_ROUND_EN
      if (w_rate != '0)
         w_rnd = AW'(1) << (w_rate - 1'b1);
`endif
      for (int k = 0; k < CH; k++) begin
         w_sum[k] = AW'($signed(datain[k*WIDTH +: WIDTH]));
         if (!w_first)
            w_sum[k] = w_sum[k] + r_acc[k];
         w_res[k] = w_mode ? WIDTH'((w_sum[k] + w_rnd) >>> w_rate)
                           : datain[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_cnt   <= '0;
         r_rate  <= '0;
         r_mode  <= 1'b0;
         r_done  <= 1'b0;
         r_go    <= 1'b0;
         overrun <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            r_acc[k]  <= '0;
            r_res[k]  <= '0;
            r_snap[k] <= '0;
         end
      end else begin
         r_s1   <= drdy;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_done <= w_stb & w_last;
         r_go   <= 1'b0;
         if (w_stb) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_first) begin
               r_rate <= w_rate_new;
               r_mode <= mode;
            end
            for (int k = 0; k < CH; k++)
               r_acc[k] <= w_sum[k];
            if (w_last)
               for (int k = 0; k < CH; k++)
                  r_res[k] <= w_res[k];
         end
         // a finished block only reaches the snapshot if no frame is in flight
         if (r_done) begin
            if (busy || r_go) begin
               overrun <= 1'b1;
            end else begin
               for (int k = 0; k < CH; k++)
                  r_snap[k] <= r_res[k];
               r_go <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st        <= S_IDLE;
         dataout     <= '0;
         chan_out    <= '0;
         data_rdy    <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         unique case (r_st)
            S_IDLE: begin
               if (r_go) begin
                  r_st        <= S_SEND;
                  dataout     <= r_snap[0];
                  chan_out    <= '0;
                  data_rdy    <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_SEND: begin
               frame_start <= 1'b0;
               if (chan_out == CHW'(CH-1)) begin
                  r_st     <= S_IDLE;
                  data_rdy <= 1'b0;
                  busy     <= 1'b0;
               end else begin
                  chan_out <= w_nxt;
                  dataout  <= r_snap[w_nxt];
               end
            end
         endcase
      end
   end

endmodule

// File: doc/cu_decimation_mc.md
Name: cu_decimation_mc

Overview:
Multi-channel, parametrised successor to the single-channel ADC decimator. It captures CH parallel ADC channels on each drdy pulse and decimates them by 2^rate. Decimation is either pick-last or boxcar average. Results are emitted as a time-multiplexed stream, one channel per clock, toward the logger FIFO/packetiser.

Parameters:
WIDTH, 16, sample width per channel (two's complement)
CH, 4, number of channels (1..16)
CHW, 2, width of channel index (ceil(log2(CH)), min 1)
RATE_MAX, 7, largest decimation exponent accepted (factor 2^RATE_MAX)
RW, 3, width of rate input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
drdy  in  1  ADC data-ready pulse, asynchronous to clk, min high 1 clk
datain  in  CH*WIDTH  channel k in bits [k*WIDTH +: WIDTH]; stable from drdy rise until 3 clk after
rate  in  RW  decimation exponent; factor = 2^rate
mode  in  1  0 = pick last sample of block, 1 = boxcar average
dataout  out  WIDTH  decimated sample for channel chan_out
chan_out  out  CHW  channel index of dataout
data_rdy  out  1  dataout/chan_out valid this cycle
frame_start  out  1  high with data_rdy on channel 0 only
busy  out  1  serializer emitting a frame
overrun  out  1  sticky: a completed block was dropped

Behaviour:
- Reset (async, reset=0): all outputs 0; sync FFs, block counter, accumulators, snapshot and serializer cleared. Asserting reset mid-frame drops data_rdy in the same instant. After release, the first block starts at the next strobe.
- drdy passes through a 2-FF synchroniser plus rising-edge detect, producing a 1-cycle strobe 3 clk after the drdy rise. datain is sampled on the strobe cycle. Back-to-back strobes are at least 2 clk apart.
- Block control: a counter counts strobes 0..N-1, with N = 2^r.
  - r is latched on the first strobe of a block: r = min(rate, RATE_MAX). A rate change mid-block takes effect only at the next block.
  - mode is also latched per block.
- Accumulators: CH signed registers, WIDTH+RATE_MAX bits each.
  - On the first strobe: acc = sign-extended sample. On later strobes: acc += sample.
- Result on the last strobe of a block:
  - mode 0: the current sample.
  - mode 1: (acc + sample) >>> r, arithmetic shift (floor), truncated to WIDTH. No overflow is possible, since the mean lies within the input range.
  - r=0: pass-through in both modes.
- Snapshot: results are written into CH output registers 1 clk after the last strobe.
  - The serializer then starts in the next cycle and emits channels 0..CH-1 on CH consecutive cycles with data_rdy=1.
  - busy=1 from the first to the last emitted word.
- Latency: first data_rdy occurs 2 clk after the last strobe of the block, i.e. 5 clk after the drdy rise.
- Accumulation continues during serialisation; the serializer reads only the snapshot.
- Overrun: if a block completes while busy=1, that block's results are discarded, the frame in progress completes unchanged, and overrun=1 until reset.
- Serializer FSM:
  - IDLE -> SEND on snapshot valid.
  - SEND increments chan_out each cycle.
  - SEND -> IDLE after chan_out = CH-1.

Optional Feature:
CU_DEC_ROUND_EN:
- Defined: mode 1 with r>0 computes (sum + 2^(r-1)) >>> r, i.e. round half up. mode 0 and r=0 are unaffected.
- Undefined: floor (truncate toward -inf) as above.

Test Plan:
- CH=1, rate=1, mode=1, drdy pulses (high 1 clk, period 31 clk), datain 10 then 9 -> one data_rdy, dataout=9 (10 with ROUND_EN), 5 clk after the 2nd drdy rise.
- rate=2, mode=0, samples 10,9,8,7 -> dataout=7; mode=1 on the same samples -> 8 (floor of 34/4 = 8; ROUND_EN gives 9).
- CH=4, rate=0, datain = {0x8000,0xFFFF,0x0002,0x0001} (ch3..ch0) -> 4 consecutive data_rdy cycles: chan_out 0..3, dataout 0x0001,0x0002,0xFFFF,0x8000, frame_start only on ch0, busy high for 4 clk.
- Signed average, rate=1, samples -2,-3 -> dataout 0xFFFD (-3); ROUND_EN -> 0xFFFE (-2).
- Rate change: rate=1, one strobe, switch rate to 3, one strobe -> block closes after 2 samples; the next block needs 8 strobes.
- CH=4, rate=0, drdy toggling every clk (edges every 2 clk) -> overrun=1, each frame still has 4 words in order. Reset low mid-frame -> data_rdy/busy/overrun=0 immediately.
